// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - decode-stage conditional branch resolution with held fetch redirect
module branch_resolve #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [2:0]       br_op,
    input  logic [15:0]      br_imm,
    input  logic [31:0]      br_pc4,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    input  logic             rs_ready,
    input  logic             rt_ready,
    input  logic             if_ack,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nt_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_OPS = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [2:0] OP_BEQ  = 3'b000;
    localparam logic [2:0] OP_BNE  = 3'b001;
    localparam logic [2:0] OP_BLEZ = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BLTZ = 3'b100;
    localparam logic [2:0] OP_BGEZ = 3'b101;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [15:0] imm_q;
    logic [31:0] pc4_q;

    logic [2:0]  op_sel;
    logic [15:0] imm_sel;
    logic [31:0] pc4_sel;
    logic [31:0] target;
    logic        ops_ready;
    logic        cond;
    logic        reserved;
    logic        resolve;
    logic        latch;
    logic        stall_c;
    logic        take;
    logic        not_take;

    // While waiting, the branch fields come from the latch; ID may hold anything.
    assign op_sel  = (state == WAIT_OPS) ? op_q  : br_op;
    assign imm_sel = (state == WAIT_OPS) ? imm_q : br_imm;
    assign pc4_sel = (state == WAIT_OPS) ? pc4_q : br_pc4;
    assign target  = pc4_sel + {{14{imm_sel[15]}}, imm_sel, 2'b00};

    assign reserved  = (op_sel[2:1] == 2'b11);
    assign ops_ready = ((op_sel == OP_BEQ) || (op_sel == OP_BNE)) ? (rs_ready & rt_ready)
                                                                   : rs_ready;

    always_comb begin
        cond = 1'b0;
        case (op_sel)
            OP_BEQ:  cond = (rs_val == rt_val);
            OP_BNE:  cond = (rs_val != rt_val);
            OP_BLEZ: cond = rs_val[31] || (rs_val == 32'd0);
            OP_BGTZ: cond = !rs_val[31] && (rs_val != 32'd0);
            OP_BLTZ: cond = rs_val[31];
            OP_BGEZ: cond = !rs_val[31];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        resolve   = 1'b0;
        latch     = 1'b0;
        unique case (state)
            IDLE: begin
                if (br_valid) begin
                    if (ops_ready) begin
                        resolve = 1'b1;
                    end else begin
                        latch     = 1'b1;
                        stall_c   = 1'b1;
                        state_nxt = WAIT_OPS;
                    end
                end
            end
            WAIT_OPS: begin
                if (ops_ready) begin
                    resolve = 1'b1;
                end else begin
                    stall_c = 1'b1;
                end
            end
            REDIRECT: begin
                stall_c = br_valid;
                if (if_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (resolve) begin
            state_nxt = (cond && !reserved) ? REDIRECT : IDLE;
        end
    end

    assign take     = resolve & cond & !reserved;
    assign not_take = resolve & !cond & !reserved;
    assign stall_id = rst_n & stall_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_q           <= 3'd0;
            imm_q          <= 16'd0;
            pc4_q          <= 32'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            taken_cnt      <= '0;
            nt_cnt         <= '0;
        end else begin
            state <= state_nxt;
            if (latch) begin
                op_q  <= br_op;
                imm_q <= br_imm;
                pc4_q <= br_pc4;
            end
            if (take) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= target;
            end else if ((state == REDIRECT) && if_ack) begin
                redirect_valid <= 1'b0;
            end
            // Statistics stick at all-ones rather than wrapping.
            if (take && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + 1'b1;
            end
            if (not_take && (nt_cnt != '1)) begin
                nt_cnt <= nt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed-vector scoreboard bench for branch_resolve
module tb_branch_resolve;

    localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLEZ = 3'b010, BGTZ = 3'b011;
    localparam logic [2:0] BLTZ = 3'b100, RSV6 = 3'b110, RSV7 = 3'b111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid;
    logic [2:0]  br_op;
    logic [15:0] br_imm;
    logic [31:0] br_pc4, rs_val, rt_val;
    logic        rs_ready, rt_ready, if_ack;
    logic        stall_id, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] taken_cnt, nt_cnt;
    logic        s_stall, s_rv;
    logic [31:0] s_pc;
    logic [1:0]  s_tc, s_nc;

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] pc;
        logic [15:0] tc;
        logic [15:0] nc;
        logic [1:0]  tcs;
        logic [1:0]  ncs;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    branch_resolve #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op), .br_imm(br_imm),
        .br_pc4(br_pc4), .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready),
        .rt_ready(rt_ready), .if_ack(if_ack), .stall_id(stall_id),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
    );

    // Narrow-counter copy so taken-counter saturation is reachable quickly.
    branch_resolve #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op), .br_imm(br_imm),
        .br_pc4(br_pc4), .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready),
        .rt_ready(rt_ready), .if_ack(if_ack), .stall_id(s_stall),
        .redirect_valid(s_rv), .redirect_pc(s_pc),
        .taken_cnt(s_tc), .nt_cnt(s_nc)
    );

    function automatic logic [1:0] sat2(input logic [15:0] x);
        return (x > 16'd3) ? 2'd3 : x[1:0];
    endfunction

    task automatic cyc(input logic rst, input logic bv, input logic [2:0] op,
                       input logic [15:0] imm, input logic [31:0] pc4, input logic [31:0] rs,
                       input logic [31:0] rt, input logic rsr, input logic rtr, input logic ack,
                       input logic est, input logic erv, input logic [31:0] epc,
                       input logic [15:0] etc, input logic [15:0] enc);
        exp_t e;
        rst_n = rst; br_valid = bv; br_op = op; br_imm = imm; br_pc4 = pc4;
        rs_val = rs; rt_val = rt; rs_ready = rsr; rt_ready = rtr; if_ack = ack;
        e.st = est; e.rv = erv; e.pc = epc; e.tc = etc; e.nc = enc;
        e.tcs = sat2(etc); e.ncs = sat2(enc);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            bad = 1'b0;
            n_vec++;
            if (stall_id !== e.st) begin
                $display("FAIL vec%0d stall_id got %0b want %0b", n_vec, stall_id, e.st); bad = 1'b1;
            end
            if (redirect_valid !== e.rv) begin
                $display("FAIL vec%0d redirect_valid got %0b want %0b", n_vec, redirect_valid, e.rv); bad = 1'b1;
            end
            if (redirect_pc !== e.pc) begin
                $display("FAIL vec%0d redirect_pc got %h want %h", n_vec, redirect_pc, e.pc); bad = 1'b1;
            end
            if (taken_cnt !== e.tc) begin
                $display("FAIL vec%0d taken_cnt got %h want %h", n_vec, taken_cnt, e.tc); bad = 1'b1;
            end
            if (nt_cnt !== e.nc) begin
                $display("FAIL vec%0d nt_cnt got %h want %h", n_vec, nt_cnt, e.nc); bad = 1'b1;
            end
            if (s_tc !== e.tcs || s_nc !== e.ncs) begin
                $display("FAIL vec%0d narrow counters got %0d/%0d want %0d/%0d",
                         n_vec, s_tc, s_nc, e.tcs, e.ncs); bad = 1'b1;
            end
            if (bad) n_miss++;
        end
    end

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; br_op = 3'd0; br_imm = 16'd0; br_pc4 = 32'd0;
        rs_val = 32'd0; rt_val = 32'd0; rs_ready = 1'b0; rt_ready = 1'b0; if_ack = 1'b0;
        @(posedge clk);
        #1;
        //  rst bv op    imm       pc4           rs            rt         rsr rtr ack  st rv pc            tc  nc
        cyc(0, 1, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 0,   0, 0, 32'h0,        0, 0);
        cyc(1, 1, BEQ,  16'h0003, 32'h00400004, 32'h1234,     32'h1234,  1, 1, 0,   0, 0, 32'h0,        0, 0);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 1,   0, 1, 32'h00400010, 1, 0);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 1,   0, 0, 32'h00400010, 1, 0);
        cyc(1, 1, BLEZ, 16'h0010, 32'h100,      32'h80000000, 32'h0,     1, 0, 0,   0, 0, 32'h00400010, 1, 0);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 1,   0, 1, 32'h140,      2, 0);
        cyc(1, 1, BGTZ, 16'h0004, 32'h200,      32'h0,        32'h0,     1, 0, 0,   0, 0, 32'h140,      2, 0);
        cyc(1, 1, BLTZ, 16'hFFFE, 32'h300,      32'hFFFFFFFF, 32'h0,     1, 0, 0,   0, 0, 32'h140,      2, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 1,   0, 1, 32'h2F8,      3, 1);
        // BNE waits three cycles on rt; later cycles present a different pc/imm in ID
        cyc(1, 1, BNE,  16'hFFFF, 32'h0,        32'h1,        32'h2,     1, 0, 0,   1, 0, 32'h2F8,      3, 1);
        cyc(1, 1, BNE,  16'h0000, 32'h1234,     32'h1,        32'h2,     1, 0, 0,   1, 0, 32'h2F8,      3, 1);
        cyc(1, 1, BNE,  16'h0000, 32'h1234,     32'h1,        32'h2,     1, 0, 0,   1, 0, 32'h2F8,      3, 1);
        cyc(1, 1, BNE,  16'h0000, 32'h1234,     32'h1,        32'h2,     1, 1, 0,   0, 0, 32'h2F8,      3, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 1,   0, 1, 32'hFFFFFFFC, 4, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 0,   0, 0, 32'hFFFFFFFC, 4, 1);
        // held redirect with a second BEQ waiting in ID
        cyc(1, 1, BEQ,  16'h0100, 32'h1000,     32'h5,        32'h5,     1, 1, 0,   0, 0, 32'hFFFFFFFC, 4, 1);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, BEQ, 16'h0001, 32'h2000,  32'h7,        32'h7,     1, 1, 0,   1, 1, 32'h1400,     5, 1);
        cyc(1, 1, BEQ,  16'h0001, 32'h2000,     32'h7,        32'h7,     1, 1, 1,   1, 1, 32'h1400,     5, 1);
        cyc(1, 1, BEQ,  16'h0001, 32'h2000,     32'h7,        32'h7,     1, 1, 0,   0, 0, 32'h1400,     5, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 1,   0, 1, 32'h2004,     6, 1);
        // reserved ops: immediate and after waiting on rs
        cyc(1, 1, RSV6, 16'h0008, 32'h500,      32'h0,        32'h0,     1, 1, 0,   0, 0, 32'h2004,     6, 1);
        cyc(1, 1, RSV7, 16'h0008, 32'h500,      32'h0,        32'h0,     0, 0, 0,   1, 0, 32'h2004,     6, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     1, 0, 0,   0, 0, 32'h2004,     6, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     1, 1, 1,   0, 0, 32'h2004,     6, 1);
        // reset in REDIRECT
        cyc(1, 1, BEQ,  16'h0000, 32'h40,       32'h9,        32'h9,     1, 1, 0,   0, 0, 32'h2004,     6, 1);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 0,   0, 1, 32'h40,       7, 1);
        cyc(0, 1, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 0,   0, 0, 32'h0,        0, 0);
        // reset in WAIT_OPS
        cyc(1, 1, BNE,  16'h0004, 32'h80,       32'h3,        32'h3,     1, 0, 0,   1, 0, 32'h0,        0, 0);
        cyc(1, 1, BNE,  16'h0004, 32'h80,       32'h3,        32'h3,     1, 0, 0,   1, 0, 32'h0,        0, 0);
        cyc(0, 1, BNE,  16'h0004, 32'h80,       32'h3,        32'h3,     1, 0, 0,   0, 0, 32'h0,        0, 0);
        cyc(1, 0, BNE,  16'h0004, 32'h80,       32'h3,        32'h4,     1, 1, 0,   0, 0, 32'h0,        0, 0);
        cyc(1, 0, BNE,  16'h0004, 32'h80,       32'h3,        32'h4,     1, 1, 0,   0, 0, 32'h0,        0, 0);
        // drive nt_cnt into saturation with back-to-back not-taken BGTZ
        for (int i = 0; i <= 65536; i++)
            cyc(1, 1, BGTZ, 16'h0004, 32'h200,  32'h0,        32'h0,     1, 0, 0,   0, 0, 32'h0,        0,
                (i > 65535) ? 16'hFFFF : 16'(i));
        cyc(1, 1, BGTZ, 16'h0004, 32'h200,      32'h0,        32'h0,     1, 0, 0,   0, 0, 32'h0,        0, 16'hFFFF);
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 0,   0, 0, 32'h0,        0, 16'hFFFF);
        // taken branches past the narrow copy's limit
        for (int k = 0; k < 5; k++) begin
            cyc(1, 1, BEQ, 16'h0001, 32'h10,    32'hA,        32'hA,     1, 1, 0,   0, 0,
                (k == 0) ? 32'h0 : 32'h14, 16'(k), 16'hFFFF);
            cyc(1, 0, BEQ, 16'h0000, 32'h0,     32'h0,        32'h0,     0, 0, 1,   0, 1, 32'h14,
                16'(k + 1), 16'hFFFF);
        end
        cyc(1, 0, BEQ,  16'h0000, 32'h0,        32'h0,        32'h0,     0, 0, 0,   0, 0, 32'h14,       5, 16'hFFFF);

        for (int t = 0; t < 5 && q.size() > 0; t++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain %0d expectations left unchecked, want 0", q.size());
            n_miss++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
